// File: rtl/rgb_seq_monitor.sv
// rgb_seq_monitor
//   Watches sampled RGB LED drive lines and checks that they follow the
//   sequence BLANK -> RED -> GREEN -> BLUE -> BLANK. Each colour must be
//   held for exactly COUNTER_MAX clk cycles. Complete legal sequences are
//   counted. The first protocol violation since the last clear is latched.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high reset
//   red/green/blue : sampled LED drive, synchronous to clk
//   err_clr    : one-cycle synchronous clear of error / err_code
//   phase      : decoded phase (BLANK=00, RED=01, GREEN=11, BLUE=10)
//   seq_done   : one-cycle pulse per complete legal sequence
//   seq_count  : number of complete legal sequences (wraps)
//   error      : sticky violation flag
//   err_code   : first violation (00 none, 01 combination, 10 order, 11 duration)
//   dbg_state  : current FSM state, for checkers
//                (0 IDLE, 1 RED, 2 GREEN, 3 BLUE, 4 RESYNC)
//
// Handshake: none. A sample is taken on every rising edge of clk.
module rgb_seq_monitor #(
  parameter int COUNTER_MAX     = 10,
  parameter int SEQ_COUNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       red,
  input  logic                       green,
  input  logic                       blue,
  input  logic                       err_clr,
  output logic [1:0]                 phase,
  output logic                       seq_done,
  output logic [SEQ_COUNT_WIDTH-1:0] seq_count,
  output logic                       error,
  output logic [1:0]                 err_code,
  output logic [2:0]                 dbg_state
);

  localparam int CW = $clog2(COUNTER_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(COUNTER_MAX);
  localparam logic [CW-1:0] CONE = CW'(1);

  localparam logic [1:0] E_COMB  = 2'b01;
  localparam logic [1:0] E_ORDER = 2'b10;
  localparam logic [1:0] E_DUR   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RED    = 3'd1,
    S_GREEN  = 3'd2,
    S_BLUE   = 3'd3,
    S_RESYNC = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [1:0]                 phase_q, phase_d;
  logic                       seq_done_q, seq_done_d;
  logic [SEQ_COUNT_WIDTH-1:0] seq_count_q;
  logic                       error_q;
  logic [1:0]                 err_code_q;
  logic                       err_hit;
  logic [1:0]                 err_kind;

  // Sample decode
  logic is_blank, is_r, is_g, is_b, is_illegal;
  assign is_blank   = ({red, green, blue} == 3'b000);
  assign is_r       = ({red, green, blue} == 3'b100);
  assign is_g       = ({red, green, blue} == 3'b010);
  assign is_b       = ({red, green, blue} == 3'b001);
  assign is_illegal = !(is_blank || is_r || is_g || is_b);

  logic   same_colour, legal_next, at_max;
  state_t next_colour;
  assign at_max      = (cnt_q == CMAX);
  assign same_colour = ((state_q == S_RED)   && is_r) ||
                       ((state_q == S_GREEN) && is_g) ||
                       ((state_q == S_BLUE)  && is_b);
  assign legal_next  = ((state_q == S_RED)   && is_g) ||
                       ((state_q == S_GREEN) && is_b) ||
                       ((state_q == S_BLUE)  && is_blank);
  assign next_colour = is_g ? S_GREEN : (is_b ? S_BLUE : S_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seq_done_d = 1'b0;
    err_hit    = 1'b0;
    err_kind   = 2'b00;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (is_illegal) begin
          err_hit  = 1'b1;
          err_kind = E_COMB;
        end else if (is_r) begin
          state_d = S_RED;
          cnt_d   = CONE;
        end else if (is_g || is_b) begin
          err_hit  = 1'b1;
          err_kind = E_ORDER;
        end
      end
      S_RED, S_GREEN, S_BLUE: begin
        // Priority: combination, then duration, then order.
        if (is_illegal) begin
          err_hit  = 1'b1;
          err_kind = E_COMB;
        end else if (same_colour) begin
          if (at_max) begin
            err_hit  = 1'b1;
            err_kind = E_DUR;
          end else begin
            cnt_d = cnt_q + CONE;
          end
        end else if (!at_max) begin
          err_hit  = 1'b1;
          err_kind = E_DUR;
        end else if (legal_next) begin
          state_d    = next_colour;
          cnt_d      = (next_colour == S_IDLE) ? '0 : CONE;
          seq_done_d = (state_q == S_BLUE);
        end else begin
          err_hit  = 1'b1;
          err_kind = E_ORDER;
        end
      end
      S_RESYNC: begin
        // Violations are not reported here; only wait for BLANK.
        cnt_d = '0;
        if (is_blank) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (err_hit) begin
      state_d = S_RESYNC;
      cnt_d   = '0;
    end
  end

  always_comb begin
    case (state_d)
      S_RED:   phase_d = 2'b01;
      S_GREEN: phase_d = 2'b11;
      S_BLUE:  phase_d = 2'b10;
      default: phase_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      phase_q     <= 2'b00;
      seq_done_q  <= 1'b0;
      seq_count_q <= '0;
      error_q     <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      seq_done_q <= seq_done_d;
      if (seq_done_d) seq_count_q <= seq_count_q + 1'b1;
      // A new error beats a simultaneous clear and latches its own code.
      if (err_hit) begin
        error_q <= 1'b1;
        if (err_clr || (err_code_q == 2'b00)) err_code_q <= err_kind;
      end else if (err_clr) begin
        error_q    <= 1'b0;
        err_code_q <= 2'b00;
      end
    end
  end

  assign phase     = phase_q;
  assign seq_done  = seq_done_q;
  assign seq_count = seq_count_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign dbg_state = state_q;

endmodule
